// File: rtl/mario_obj_dma_ctrl.sv
// Once-per-frame object DMA: on the falling edge of vertical blank, borrows the CPU
// bus via BUSRQ/BUSAK and copies XFER_LEN bytes from SRC_BASE into the object buffer.
module mario_obj_dma_ctrl #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter int          XFER_LEN = 384
) (
  input  logic        I_CLK,
  input  logic        I_RST_n,
  input  logic        I_CEN,
  input  logic        I_V_BLANKn,
  input  logic        I_ENABLE,
  output logic        O_BUSRQn,
  input  logic        I_BUSAKn,
  output logic [15:0] O_SRC_ADDR,
  output logic        O_SRC_RDn,
  input  logic [7:0]  I_SRC_DATA,
  output logic [8:0]  O_DST_ADDR,
  output logic [7:0]  O_DST_DATA,
  output logic        O_DST_WE,
  output logic        O_BUSY,
  output logic        O_DONE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

  state_t     state;
  logic [8:0] cnt;
  logic       vbl_hist;
  logic [8:0] cnt_nxt;
  logic       trigger;

  assign cnt_nxt = cnt + 9'd1;
  assign trigger = vbl_hist && !I_V_BLANKn && I_ENABLE && (state == S_IDLE);

  // Bus handshake: BUSRQn is held low from REQ until the last byte is written;
  // a read is only started on a CEN edge that samples BUSAKn low, and the bus
  // counts as returned only once BUSAKn is sampled high again in RELEASE.
  always_ff @(posedge I_CLK or negedge I_RST_n) begin
    if (!I_RST_n) begin
      state      <= S_IDLE;
      cnt        <= 9'd0;
      vbl_hist   <= 1'b1;
      O_BUSRQn   <= 1'b1;
      O_SRC_RDn  <= 1'b1;
      O_SRC_ADDR <= SRC_BASE;
      O_DST_ADDR <= 9'd0;
      O_DST_DATA <= 8'd0;
      O_DST_WE   <= 1'b0;
      O_BUSY     <= 1'b0;
      O_DONE     <= 1'b0;
    end else begin
      // DONE is a single system-clock pulse, so it clears on every edge.
      O_DONE <= 1'b0;
      if (I_CEN) begin
        vbl_hist <= I_V_BLANKn;
        case (state)
          S_IDLE: begin
            if (trigger) begin
              cnt      <= 9'd0;
              state    <= S_REQ;
              O_BUSRQn <= 1'b0;
              O_BUSY   <= 1'b1;
            end
          end
          S_REQ: begin
            if (!I_BUSAKn) begin
              state      <= S_READ;
              O_SRC_RDn  <= 1'b0;
              O_SRC_ADDR <= SRC_BASE + {7'd0, cnt};
            end
          end
          S_READ: begin
            // The read finishes even if acknowledge was lost during it.
            state      <= S_WRITE;
            O_DST_DATA <= I_SRC_DATA;
            O_DST_ADDR <= cnt;
            O_DST_WE   <= 1'b1;
            O_SRC_RDn  <= 1'b1;
          end
          S_WRITE: begin
            O_DST_WE <= 1'b0;
            if (cnt == LAST) begin
              state    <= S_RELEASE;
              O_BUSRQn <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
              if (!I_BUSAKn) begin
                state      <= S_READ;
                O_SRC_RDn  <= 1'b0;
                O_SRC_ADDR <= SRC_BASE + {7'd0, cnt_nxt};
              end else begin
                state <= S_REQ;
              end
            end
          end
          S_RELEASE: begin
            if (I_BUSAKn) begin
              state  <= S_IDLE;
              O_BUSY <= 1'b0;
              O_DONE <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mario_obj_dma_ctrl.sv
// Directed bench for mario_obj_dma_ctrl: a short wrapping instance (FFFE, 4 bytes)
// and a default instance (6900, 384 bytes) for the mid-transfer reset scenario.
module tb_mario_obj_dma_ctrl;

  logic clk = 1'b0;
  logic cen = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic vbl_a = 1'b1, vbl_b = 1'b1;
  logic busak_a = 1'b1, busak_b = 1'b1;

  logic        busrq_a, rdn_a, we_a, busy_a, done_a;
  logic [15:0] src_addr_a;
  logic [7:0]  src_data_a, dst_data_a;
  logic [8:0]  dst_addr_a;
  logic        busrq_b, rdn_b, we_b, busy_b, done_b;
  logic [15:0] src_addr_b;
  logic [7:0]  src_data_b, dst_data_b;
  logic [8:0]  dst_addr_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;

  logic [16:0] wr_a_q[$];
  logic [15:0] rd_a_q[$];
  logic [16:0] wr_b_q[$];
  logic [16:0] exp_q[$];
  logic [15:0] exp_rd_q[$];
  logic we_a_d = 1'b0, rdn_a_d = 1'b1, we_b_d = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'hFFFE: mem_byte = 8'h11;
      16'hFFFF: mem_byte = 8'h22;
      16'h0000: mem_byte = 8'h33;
      16'h0001: mem_byte = 8'h44;
      default:  mem_byte = a[7:0] ^ a[15:8];
    endcase
  endfunction

  assign src_data_a = mem_byte(src_addr_a);
  assign src_data_b = mem_byte(src_addr_b);

  mario_obj_dma_ctrl #(.SRC_BASE(16'hFFFE), .XFER_LEN(4)) dut_a (
    .I_CLK(clk), .I_RST_n(rst_n), .I_CEN(cen), .I_V_BLANKn(vbl_a), .I_ENABLE(enable),
    .O_BUSRQn(busrq_a), .I_BUSAKn(busak_a), .O_SRC_ADDR(src_addr_a), .O_SRC_RDn(rdn_a),
    .I_SRC_DATA(src_data_a), .O_DST_ADDR(dst_addr_a), .O_DST_DATA(dst_data_a),
    .O_DST_WE(we_a), .O_BUSY(busy_a), .O_DONE(done_a)
  );

  mario_obj_dma_ctrl dut_b (
    .I_CLK(clk), .I_RST_n(rst_n), .I_CEN(cen), .I_V_BLANKn(vbl_b), .I_ENABLE(enable),
    .O_BUSRQn(busrq_b), .I_BUSAKn(busak_b), .O_SRC_ADDR(src_addr_b), .O_SRC_RDn(rdn_b),
    .I_SRC_DATA(src_data_b), .O_DST_ADDR(dst_addr_b), .O_DST_DATA(dst_data_b),
    .O_DST_WE(we_b), .O_BUSY(busy_b), .O_DONE(done_b)
  );

  // Clock / clock-enable (one system clock in four)
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) begin
        @(negedge clk);
        cen = 1'b0;
      end
      @(negedge clk);
      cen = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Write/read/done logging, sampled mid-cycle
  always @(negedge clk) begin
    if (we_a && !we_a_d) wr_a_q.push_back({dst_addr_a, dst_data_a});
    if (!rdn_a && rdn_a_d) rd_a_q.push_back(src_addr_a);
    if (we_b && !we_b_d) wr_b_q.push_back({dst_addr_b, dst_data_b});
    if (done_a) done_a_cnt++;
    if (done_b) done_b_cnt++;
    we_a_d = we_a;
    rdn_a_d = rdn_a;
    we_b_d = we_b;
  end

  task automatic wait_cen();
    do @(posedge clk); while (cen !== 1'b1);
    #1;
  endtask

  task automatic clear_a();
    wr_a_q.delete();
    rd_a_q.delete();
    done_a_cnt = 0;
  endtask

  task automatic load_exp_a();
    exp_q.delete();
    exp_rd_q.delete();
    exp_q.push_back({9'd0, 8'h11});
    exp_q.push_back({9'd1, 8'h22});
    exp_q.push_back({9'd2, 8'h33});
    exp_q.push_back({9'd3, 8'h44});
    exp_rd_q.push_back(16'hFFFE);
    exp_rd_q.push_back(16'hFFFF);
    exp_rd_q.push_back(16'h0000);
    exp_rd_q.push_back(16'h0001);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (busrq_a !== 1'b1) $display("FAIL rst_busrq: got %b want 1", busrq_a); else pass_cnt++;
    total_cnt++; if (rdn_a !== 1'b1) $display("FAIL rst_rdn: got %b want 1", rdn_a); else pass_cnt++;
    total_cnt++; if (src_addr_a !== 16'hFFFE) $display("FAIL rst_src_a: got %h want fffe", src_addr_a); else pass_cnt++;
    total_cnt++; if (src_addr_b !== 16'h6900) $display("FAIL rst_src_b: got %h want 6900", src_addr_b); else pass_cnt++;
    total_cnt++; if (dst_addr_a !== 9'd0) $display("FAIL rst_dst_addr: got %h want 0", dst_addr_a); else pass_cnt++;
    total_cnt++; if (dst_data_a !== 8'd0) $display("FAIL rst_dst_data: got %h want 0", dst_data_a); else pass_cnt++;
    total_cnt++; if ({we_a, busy_a, done_a} !== 3'b000) $display("FAIL rst_we_busy_done: got %b want 000", {we_a, busy_a, done_a}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) wait_cen();
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL rst_idle_after: got %b want 0", busy_a); else pass_cnt++;
  endtask

  task automatic test_basic_transfer();
    int n;
    wait_cen();
    clear_a();
    busak_a = 1'b1;
    vbl_a = 1'b0;
    total_cnt++; if (busrq_a !== 1'b1) $display("FAIL basic_pre_req: got %b want 1", busrq_a); else pass_cnt++;
    wait_cen();
    total_cnt++; if ({busrq_a, busy_a} !== 2'b01) $display("FAIL basic_req: busrq/busy got %b want 01", {busrq_a, busy_a}); else pass_cnt++;
    repeat (2) wait_cen();
    total_cnt++; if ({busrq_a, rdn_a} !== 2'b01) $display("FAIL basic_wait_ack: busrq/rdn got %b want 01", {busrq_a, rdn_a}); else pass_cnt++;
    busak_a = 1'b0;
    wait_cen();
    total_cnt++; if (rdn_a !== 1'b0 || src_addr_a !== 16'hFFFE) $display("FAIL basic_first_read: rdn %b addr %h want 0 fffe", rdn_a, src_addr_a); else pass_cnt++;
    n = 0;
    while (busrq_a === 1'b0 && n < 40) begin
      wait_cen();
      n++;
    end
    total_cnt++; if (n !== 8) $display("FAIL basic_read_to_release: got %0d CEN periods want 8", n); else pass_cnt++;
    wait_cen();
    total_cnt++; if (busy_a !== 1'b1 || done_a_cnt !== 0) $display("FAIL basic_release_hold: busy %b done %0d want 1 0", busy_a, done_a_cnt); else pass_cnt++;
    busak_a = 1'b1;
    wait_cen();
    total_cnt++; if ({done_a, busy_a} !== 2'b10) $display("FAIL basic_done_set: done/busy got %b want 10", {done_a, busy_a}); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (done_a !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done_a); else pass_cnt++;
    total_cnt++; if (done_a_cnt !== 1) $display("FAIL basic_done_count: got %0d want 1", done_a_cnt); else pass_cnt++;
    load_exp_a();
    total_cnt++; if (wr_a_q.size() !== 4) $display("FAIL basic_write_count: got %0d want 4", wr_a_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wr_a_q.size() || wr_a_q[i] !== exp_q[i]) $display("FAIL basic_write_%0d: got %h want %h", i, (i < wr_a_q.size()) ? wr_a_q[i] : 17'h1ffff, exp_q[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= rd_a_q.size() || rd_a_q[i] !== exp_rd_q[i]) $display("FAIL wrap_src_addr_%0d: got %h want %h", i, (i < rd_a_q.size()) ? rd_a_q[i] : 16'hDEAD, exp_rd_q[i]);
      else pass_cnt++;
    end
    vbl_a = 1'b1;
    wait_cen();
  endtask

  task automatic test_enable_low();
    int bad;
    clear_a();
    enable = 1'b0;
    busak_a = 1'b1;
    vbl_a = 1'b0;
    bad = 0;
    repeat (6) begin
      wait_cen();
      if (busrq_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL enable_low_no_req: got %0d bad samples want 0", bad); else pass_cnt++;
    total_cnt++; if (wr_a_q.size() !== 0) $display("FAIL enable_low_no_write: got %0d writes want 0", wr_a_q.size()); else pass_cnt++;
    vbl_a = 1'b1;
    wait_cen();
    enable = 1'b1;
    wait_cen();
  endtask

  task automatic test_ignored_edge();
    int n;
    clear_a();
    busak_a = 1'b1;
    vbl_a = 1'b0;
    wait_cen();
    total_cnt++; if (busrq_a !== 1'b0) $display("FAIL ignored_req: got %b want 0", busrq_a); else pass_cnt++;
    vbl_a = 1'b1;
    wait_cen();
    vbl_a = 1'b0;
    wait_cen();
    busak_a = 1'b0;
    n = 0;
    do begin
      wait_cen();
      n++;
    end while (busrq_a === 1'b0 && n < 40);
    total_cnt++; if (busrq_a !== 1'b1) $display("FAIL ignored_release_timeout: busrq got %b want 1", busrq_a); else pass_cnt++;
    busak_a = 1'b1;
    repeat (6) wait_cen();
    total_cnt++; if (wr_a_q.size() !== 4) $display("FAIL ignored_write_count: got %0d want 4", wr_a_q.size()); else pass_cnt++;
    total_cnt++; if (done_a_cnt !== 1) $display("FAIL ignored_done_count: got %0d want 1", done_a_cnt); else pass_cnt++;
    total_cnt++; if ({busrq_a, busy_a} !== 2'b10) $display("FAIL ignored_no_restart: busrq/busy got %b want 10", {busrq_a, busy_a}); else pass_cnt++;
    vbl_a = 1'b1;
    wait_cen();
  endtask

  task automatic test_ack_dropout();
    int n;
    int bad;
    clear_a();
    busak_a = 1'b0;
    vbl_a = 1'b0;
    wait_cen();
    wait_cen();
    // Enable and vblank both go away mid-transfer; neither may abort it.
    enable = 1'b0;
    vbl_a = 1'b1;
    n = 0;
    while (!(we_a === 1'b1 && dst_addr_a === 9'd1) && n < 20) begin
      wait_cen();
      n++;
    end
    total_cnt++; if (we_a !== 1'b1 || dst_addr_a !== 9'd1) $display("FAIL dropout_byte1: we %b addr %h want 1 001", we_a, dst_addr_a); else pass_cnt++;
    busak_a = 1'b1;
    wait_cen();
    total_cnt++; if ({busrq_a, rdn_a, we_a, busy_a} !== 4'b0101) $display("FAIL dropout_park: busrq/rdn/we/busy got %b want 0101", {busrq_a, rdn_a, we_a, busy_a}); else pass_cnt++;
    bad = 0;
    repeat (4) begin
      wait_cen();
      if (rdn_a !== 1'b1 || busrq_a !== 1'b0) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL dropout_hold: got %0d bad samples want 0", bad); else pass_cnt++;
    busak_a = 1'b0;
    wait_cen();
    total_cnt++; if (rdn_a !== 1'b0 || src_addr_a !== 16'h0000) $display("FAIL dropout_resume: rdn %b addr %h want 0 0000", rdn_a, src_addr_a); else pass_cnt++;
    n = 0;
    while (busrq_a === 1'b0 && n < 40) begin
      wait_cen();
      n++;
    end
    busak_a = 1'b1;
    repeat (3) wait_cen();
    load_exp_a();
    total_cnt++; if (wr_a_q.size() !== 4 || rd_a_q.size() !== 4) $display("FAIL dropout_counts: writes %0d reads %0d want 4 4", wr_a_q.size(), rd_a_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (i >= wr_a_q.size() || i >= rd_a_q.size() || wr_a_q[i] !== exp_q[i] || rd_a_q[i] !== exp_rd_q[i])
        $display("FAIL dropout_byte_%0d: write %h read %h want %h %h", i, (i < wr_a_q.size()) ? wr_a_q[i] : 17'h1ffff, (i < rd_a_q.size()) ? rd_a_q[i] : 16'hDEAD, exp_q[i], exp_rd_q[i]);
      else pass_cnt++;
    end
    total_cnt++; if (done_a_cnt !== 1) $display("FAIL dropout_done_count: got %0d want 1", done_a_cnt); else pass_cnt++;
    enable = 1'b1;
    wait_cen();
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    wr_b_q.delete();
    done_b_cnt = 0;
    busak_b = 1'b0;
    vbl_b = 1'b0;
    n = 0;
    while (!(we_b === 1'b1 && dst_addr_b === 9'd199) && n < 2000) begin
      wait_cen();
      n++;
    end
    total_cnt++; if (we_b !== 1'b1 || dst_addr_b !== 9'd199) $display("FAIL rstmid_reach: we %b addr %h want 1 0c7", we_b, dst_addr_b); else pass_cnt++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busrq_b, rdn_b, we_b, busy_b} !== 4'b1100) $display("FAIL rstmid_outputs: busrq/rdn/we/busy got %b want 1100", {busrq_b, rdn_b, we_b, busy_b}); else pass_cnt++;
    total_cnt++; if (src_addr_b !== 16'h6900 || dst_addr_b !== 9'd0) $display("FAIL rstmid_addrs: src %h dst %h want 6900 000", src_addr_b, dst_addr_b); else pass_cnt++;
    vbl_b = 1'b1;
    busak_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) wait_cen();
    total_cnt++; if (done_b_cnt !== 0 || busy_b !== 1'b0) $display("FAIL rstmid_no_done: done %0d busy %b want 0 0", done_b_cnt, busy_b); else pass_cnt++;
    wr_b_q.delete();
    busak_b = 1'b0;
    vbl_b = 1'b0;
    n = 0;
    while (we_b !== 1'b1 && n < 20) begin
      wait_cen();
      n++;
    end
    total_cnt++; if (we_b !== 1'b1 || dst_addr_b !== 9'd0 || dst_data_b !== 8'h69) $display("FAIL rstmid_restart: we %b addr %h data %h want 1 000 69", we_b, dst_addr_b, dst_data_b); else pass_cnt++;
    n = 0;
    while (busrq_b === 1'b0 && n < 2000) begin
      wait_cen();
      n++;
    end
    busak_b = 1'b1;
    repeat (3) wait_cen();
    total_cnt++; if (wr_b_q.size() !== 384) $display("FAIL rstmid_write_count: got %0d want 384", wr_b_q.size()); else pass_cnt++;
    total_cnt++; if (wr_b_q.size() == 0 || wr_b_q[wr_b_q.size() - 1] !== {9'd383, 8'h15}) $display("FAIL rstmid_last_write: got %h want %h", (wr_b_q.size() > 0) ? wr_b_q[wr_b_q.size() - 1] : 17'h1ffff, {9'd383, 8'h15}); else pass_cnt++;
    total_cnt++; if (done_b_cnt !== 1) $display("FAIL rstmid_done_count: got %0d want 1", done_b_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_transfer();
    test_enable_low();
    test_ignored_edge();
    test_ack_dropout();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
